// File: rtl/intc_pkg.sv
// Shared constants, state encoding and vector helper for the vectored interrupt controller.
package intc_pkg;

  localparam int MAX_IRQ = 8;

  localparam logic [7:0] OFS_ENABLE  = 8'h00;
  localparam logic [7:0] OFS_PENDING = 8'h01;
  localparam logic [7:0] OFS_MODE    = 8'h02;
  localparam logic [7:0] OFS_INSVC   = 8'h03;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } stateT;

  function automatic logic [15:0] vecAddr(input logic [15:0] base, input int stride,
                                          input logic [2:0] id);
    return base + 16'(stride) * 16'(id);
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder; valid is low when no request bit is set.
module intc_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [2:0]   id
);

  // Scanning from the top down lets the lowest set index overwrite any higher one.
  always_comb begin
    valid = 1'b0;
    id    = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = 3'(i);
      end
    end
  end

endmodule

// File: rtl/vectored_int_ctrl.sv
// Vectored interrupt controller: I/O-mapped enable/pending/mode/in-service registers and a request FSM.
// Nested servicing of higher-priority sources is built when INTC_NESTING_EN is defined.
module vectored_int_ctrl
  import intc_pkg::*;
#(
  parameter int          NUM_IRQ       = 8,
  parameter logic [15:0] VECTOR_BASE   = 16'h00F0,
  parameter int          VECTOR_STRIDE = 2,
  parameter logic [7:0]  IO_BASE       = 8'h20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [7:0]         io_addr,
  input  logic [7:0]         io_wdata,
  input  logic               io_we,
  input  logic               io_re,
  output logic [7:0]         io_rdata,
  output logic               int_req,
  output logic [15:0]        int_vector,
  input  logic               int_ack,
  input  logic               int_ret
);

  localparam logic [7:0] CH_MASK      = 8'((9'd1 << NUM_IRQ) - 9'd1);
  localparam logic [7:0] ADDR_ENABLE  = IO_BASE + OFS_ENABLE;
  localparam logic [7:0] ADDR_PENDING = IO_BASE + OFS_PENDING;
  localparam logic [7:0] ADDR_MODE    = IO_BASE + OFS_MODE;
  localparam logic [7:0] ADDR_INSVC   = IO_BASE + OFS_INSVC;

  stateT       state;
  logic [2:0]  reqId;
  logic [7:0]  enableReg, pendingReg, modeReg, inService;
  logic [7:0]  irqExt, irqQ, irqPrev;
  logic [7:0]  eligible, candidate, thrMask, retMask, insvcAfterRet;
  logic [7:0]  w1cMask, ackClr, edgeSet, pendingNext;
  logic        winValid, insvcValid;
  logic [2:0]  winId, insvcId;
  logic        wrEnable, wrPending, wrMode;

  assign irqExt = 8'(irq);

  assign wrEnable  = io_we && (io_addr == ADDR_ENABLE);
  assign wrPending = io_we && (io_addr == ADDR_PENDING);
  assign wrMode    = io_we && (io_addr == ADDR_MODE);

  // Only channels strictly above (lower index than) the lowest in-service bit may compete.
  assign eligible  = pendingReg & enableReg & ~inService;
  assign thrMask   = insvcValid ? ((8'd1 << insvcId) - 8'd1) : 8'hFF;
  assign candidate = eligible & thrMask;

  assign retMask       = 8'd1 << insvcId;
  assign insvcAfterRet = inService & ~retMask;

  intc_prio_enc #(.N(NUM_IRQ)) uWinEnc (
    .req   (candidate[NUM_IRQ-1:0]),
    .valid (winValid),
    .id    (winId)
  );

  intc_prio_enc #(.N(NUM_IRQ)) uInsvcEnc (
    .req   (inService[NUM_IRQ-1:0]),
    .valid (insvcValid),
    .id    (insvcId)
  );

  // Edge channels latch until acked or W1C (a new edge beats a clear); level channels mirror irqQ.
  assign w1cMask     = wrPending ? io_wdata : 8'h00;
  assign ackClr      = (state == REQ && int_ack) ? (8'd1 << reqId) : 8'h00;
  assign edgeSet     = irqQ & ~irqPrev;
  assign pendingNext = (modeReg & ((pendingReg & ~(w1cMask | ackClr)) | edgeSet))
                     | (~modeReg & irqQ);

  always_comb begin
    io_rdata = 8'h00;
    if (io_re) begin
      case (io_addr)
        ADDR_ENABLE:  io_rdata = enableReg;
        ADDR_PENDING: io_rdata = pendingReg;
        ADDR_MODE:    io_rdata = modeReg;
        ADDR_INSVC:   io_rdata = inService;
        default:      io_rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irqQ       <= 8'h00;
      irqPrev    <= 8'h00;
      pendingReg <= 8'h00;
      enableReg  <= 8'h00;
      modeReg    <= 8'h00;
    end else begin
      irqQ       <= irqExt;
      irqPrev    <= irqQ;
      pendingReg <= pendingNext;
      if (wrEnable) enableReg <= io_wdata & CH_MASK;
      if (wrMode)   modeReg   <= io_wdata & CH_MASK;
    end
  end

  // The serviced channel is reqId, i.e. the one whose vector is on int_vector during the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      int_vector <= VECTOR_BASE;
      reqId      <= 3'd0;
      inService  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (winValid) begin
            state      <= REQ;
            int_req    <= 1'b1;
            int_vector <= vecAddr(VECTOR_BASE, VECTOR_STRIDE, winId);
            reqId      <= winId;
          end
        end
        REQ: begin
          if (int_ack) begin
            state     <= SVC;
            int_req   <= 1'b0;
            inService <= inService | (8'd1 << reqId);
          end else if (!winValid) begin
            state   <= (inService != 8'h00) ? SVC : IDLE;
            int_req <= 1'b0;
          end else begin
            int_vector <= vecAddr(VECTOR_BASE, VECTOR_STRIDE, winId);
            reqId      <= winId;
          end
        end
        SVC: begin
          if (int_ret && insvcValid) begin
            inService <= insvcAfterRet;
            if (insvcAfterRet == 8'h00) state <= IDLE;
          end
`ifdef INTC_NESTING_EN
          else if (winValid) begin
            state      <= REQ;
            int_req    <= 1'b1;
            int_vector <= vecAddr(VECTOR_BASE, VECTOR_STRIDE, winId);
            reqId      <= winId;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
